regfile_write_queue: RTL

//  Writer-side agent for register_file: buffers writeback results from the

---
 rtl/regfile_write_queue_pkg.sv | 7 +
 rtl/regfile_write_queue_bypass_match.sv | 33 +++
 rtl/regfile_write_queue.sv | 102 ++++++++++
 3 files changed

// File: rtl/regfile_write_queue_pkg.sv
// Shared register-file parameters for the regfile write queue and its bypass search.
package regfile_write_queue_pkg;
    localparam int DEF_DATA_W   = 20;
    localparam int DEF_SEL_W    = 4;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_DEPTH    = 4;
endpackage

// File: rtl/regfile_write_queue_bypass_match.sv
// Youngest-match search over the pending write queue for one read select.
module regfile_bypass_match
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][SEL_W-1:0]  sel,
    input  logic [DEPTH-1:0][DATA_W-1:0] data,
    input  logic [PTR_W-1:0]             head,
    input  logic [SEL_W-1:0]             r_select,
    output logic                         hit,
    output logic [DATA_W-1:0]            hit_data
);
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest from head so the last match found is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && (sel[idx] == r_select)) begin
                hit      = 1'b1;
                hit_data = data[idx];
            end
        end
    end
endmodule

// File: rtl/regfile_write_queue.sv
// Writer-side FIFO for register_file: drains one result per cycle and forwards pending values.
module regfile_write_queue
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              drain_en,
    output logic [DATA_W-1:0] rf_write,
    output logic [SEL_W-1:0]  rf_w_select,
    output logic              rf_w,
    input  logic [SEL_W-1:0]  r1_select,
    input  logic [SEL_W-1:0]  r2_select,
    output logic              r1_hit,
    output logic [DATA_W-1:0] r1_data,
    output logic              r2_hit,
    output logic [DATA_W-1:0] r2_data,
    output logic [CNT_W-1:0]  count
);
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [DEPTH-1:0][SEL_W-1:0]  sel_q, sel_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [PTR_W-1:0]             head_q, head_d;
    logic [PTR_W-1:0]             tail_q, tail_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         push, pop, not_empty;

    // Pop clears the head slot before push sets the tail, so a full push+pop reuses the slot.
    always_comb begin
        not_empty   = (count_q != '0);
        rf_w        = not_empty & drain_en;
        pop         = rf_w;
        in_ready    = (count_q < CNT_W'(DEPTH)) | rf_w;
        push        = in_valid & in_ready;
        rf_write    = not_empty ? data_q[head_q] : '0;
        rf_w_select = not_empty ? sel_q[head_q]  : '0;
        count       = count_q;

        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push) begin
            data_d[tail_q]  = in_data;
            sel_d[tail_q]   = in_sel;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    regfile_bypass_match #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W), .PTR_W(PTR_W)
    ) u_match_r1 (
        .valid(valid_q), .sel(sel_q), .data(data_q), .head(head_q),
        .r_select(r1_select), .hit(r1_hit), .hit_data(r1_data)
    );

    regfile_bypass_match #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W), .PTR_W(PTR_W)
    ) u_match_r2 (
        .valid(valid_q), .sel(sel_q), .data(data_q), .head(head_q),
        .r_select(r2_select), .hit(r2_hit), .hit_data(r2_data)
    );
endmodule
